// File: rtl/sw_debounce_if.sv
// Switch conditioner bus: raw switch levels in, debounced levels and
// per-bit edge pulses out.
interface sw_debounce_if #(
   parameter int WIDTH = 4
) ();
   logic [WIDTH-1:0] sw_i;
   logic [WIDTH-1:0] sw_o;
   logic [WIDTH-1:0] sw_rise;
   logic [WIDTH-1:0] sw_fall;
   logic             sw_chg;

   // Board side: drives the raw switches and consumes the clean levels/pulses.
   modport master (
      output sw_i,
      input  sw_o,
      input  sw_rise,
      input  sw_fall,
      input  sw_chg
   );

   // Debouncer side.
   modport slave (
      input  sw_i,
      output sw_o,
      output sw_rise,
      output sw_fall,
      output sw_chg
   );
endinterface

// File: rtl/sw_debounce.sv
// Per-bit switch debouncer: two-flop synchroniser, per-bit stability counter,
// registered clean level and single-cycle rise/fall/change pulses.
module sw_debounce #(
   parameter int               WIDTH           = 4,
   parameter int               DEBOUNCE_CYCLES = 240000,
   parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
   input logic          clk,
   input logic          rst,
   sw_debounce_if.slave sw_bus
);

   localparam int               CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0]            s1_q, s1_d;
   logic [WIDTH-1:0]            s2_q, s2_d;
   logic [WIDTH-1:0]            sw_o_q, sw_o_d;
   logic [WIDTH-1:0]            sw_prev_q, sw_prev_d;
   logic [WIDTH-1:0]            rise_q, rise_d;
   logic [WIDTH-1:0]            fall_q, fall_d;
   logic                        chg_q, chg_d;
   logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

   // Synchronise, count consecutive disagreeing cycles per bit, and derive
   // edge pulses from the registered level and its one-cycle-delayed copy.
   always_comb begin
      s1_d      = sw_bus.sw_i;
      s2_d      = s1_q;
      sw_o_d    = sw_o_q;
      cnt_d     = cnt_q;
      sw_prev_d = sw_o_q;
      for (int i = 0; i < WIDTH; i++) begin
         if (s2_q[i] == sw_o_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_TC) begin
            sw_o_d[i] = s2_q[i];
            cnt_d[i]  = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
      // sw_prev_q is loaded with RESET_VAL alongside sw_o_q, so reset never
      // produces a pulse.
      rise_d = sw_o_q & ~sw_prev_q;
      fall_d = ~sw_o_q & sw_prev_q;
      chg_d  = (|rise_d) | (|fall_d);
   end

   // State registers; reset discards any count in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q      <= RESET_VAL;
         s2_q      <= RESET_VAL;
         sw_o_q    <= RESET_VAL;
         sw_prev_q <= RESET_VAL;
         rise_q    <= '0;
         fall_q    <= '0;
         chg_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         sw_o_q    <= sw_o_d;
         sw_prev_q <= sw_prev_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         chg_q     <= chg_d;
         cnt_q     <= cnt_d;
      end
   end

   assign sw_bus.sw_o    = sw_o_q;
   assign sw_bus.sw_rise = rise_q;
   assign sw_bus.sw_fall = fall_q;
   assign sw_bus.sw_chg  = chg_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with DEBOUNCE_CYCLES=4.
// Inputs change 1 ns after a rising edge; a change is first sampled on the
// next edge and appears on sw_o on the 6th edge, pulses on the 7th.
module tb_sw_debounce;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   sw_debounce_if #(.WIDTH(4)) bus ();

   sw_debounce #(
      .WIDTH          (4),
      .DEBOUNCE_CYCLES(4),
      .RESET_VAL      (4'b0000)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .sw_bus(bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_quiet(input string tag, input logic [3:0] exp_o);
      check({tag, "_o"}, 32'(bus.sw_o), 32'(exp_o));
      check({tag, "_rise"}, 32'(bus.sw_rise), 32'h0);
      check({tag, "_fall"}, 32'(bus.sw_fall), 32'h0);
      check({tag, "_chg"}, 32'(bus.sw_chg), 32'h0);
   endtask

   // Apply a clean step and check the exact update/pulse timing.
   task automatic step_to(input string tag, input logic [3:0] old_v, input logic [3:0] new_v);
      bus.sw_i = new_v;
      for (int c = 0; c < 5; c++) begin
         tick();
         check_quiet({tag, "_wait"}, old_v);
      end
      tick();
      check_quiet({tag, "_upd"}, new_v);
      tick();
      check({tag, "_rise"}, 32'(bus.sw_rise), 32'(new_v & ~old_v));
      check({tag, "_fall"}, 32'(bus.sw_fall), 32'(old_v & ~new_v));
      check({tag, "_chg"}, 32'(bus.sw_chg), 32'h1);
      check({tag, "_o"}, 32'(bus.sw_o), 32'(new_v));
      tick();
      check_quiet({tag, "_after"}, new_v);
   endtask

   initial begin
      logic [3:0] prev_v;
      logic [3:0] v;

      // Reset held with all switches high.
      rst = 1'b1;
      bus.sw_i = 4'b1111;
      #1;
      check_quiet("reset0", 4'b0000);
      for (int c = 0; c < 10; c++) begin
         tick();
         check_quiet("reset", 4'b0000);
      end
      rst = 1'b0;
      bus.sw_i = 4'b0000;
      for (int c = 0; c < 8; c++) begin
         tick();
         check_quiet("post_reset", 4'b0000);
      end

      // One-hot walk, each value held 20 cycles.
      prev_v = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         v = 4'b0001 << k;
         step_to("walk", prev_v, v);
         for (int c = 0; c < 12; c++) begin
            tick();
            check_quiet("walk_hold", v);
         end
         prev_v = v;
      end

      // Bounce on bit 0: toggles every 2 cycles for 20 cycles, then holds 1.
      for (int p = 0; p < 10; p++) begin
         bus.sw_i = (p % 2 == 0) ? 4'b1001 : 4'b1000;
         for (int c = 0; c < 2; c++) begin
            tick();
            check_quiet("bounce", 4'b1000);
         end
      end
      step_to("bounce_end", 4'b1000, 4'b1001);

      // 3-cycle glitch on bit 2 must be rejected.
      bus.sw_i = 4'b1101;
      for (int c = 0; c < 3; c++) begin
         tick();
         check_quiet("glitch_hi", 4'b1001);
      end
      bus.sw_i = 4'b1001;
      for (int c = 0; c < 12; c++) begin
         tick();
         check_quiet("glitch_lo", 4'b1001);
      end

      // Simultaneous change of all bits.
      step_to("clear", 4'b1001, 4'b0000);
      for (int c = 0; c < 4; c++) tick();
      step_to("all", 4'b0000, 4'b1111);

      // Reset asserted mid-count.
      step_to("pre_rst", 4'b1111, 4'b0001);
      bus.sw_i = 4'b0000;
      tick();
      tick();
      #2;
      rst = 1'b1;
      #1;
      check_quiet("rst_mid", 4'b0000);
      for (int c = 0; c < 3; c++) begin
         tick();
         check_quiet("rst_mid_hold", 4'b0000);
      end
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         check_quiet("rst_mid_rel", 4'b0000);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- 4-bit switch input conditioner for the 12 MHz board clock domain.
- Each raw, asynchronous, bouncing switch input is synchronised, debounced per bit, and presented as a clean level.
- Single-cycle rise and fall pulses are provided per bit.
- Sits between the board switch pins and the heartbeat/LED control logic.

Parameters:
- WIDTH, 4: number of switch bits.
- DEBOUNCE_CYCLES, 240000: consecutive stable clock cycles required to accept a new level. Default is 20 ms at 12 MHz. Legal range 1 to 2^24-1.
- RESET_VAL, 4'b0000: WIDTH-bit value loaded into the synchroniser and sw_o on reset.

Ports:
- clk  input  1  system clock, 12 MHz nominal; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- sw_i  input  WIDTH  raw switch levels; asynchronous and may bounce.
- sw_o  output  WIDTH  debounced switch levels, registered.
- sw_rise  output  WIDTH  1-cycle pulse when the matching sw_o bit goes 0->1.
- sw_fall  output  WIDTH  1-cycle pulse when the matching sw_o bit goes 1->0.
- sw_chg  output  1  OR of all sw_rise and sw_fall bits, registered in the same cycle as the pulses.

Behaviour:
- Reset (rst=1, asynchronous assert):
  - sync stage 1, sync stage 2 and sw_o are set to RESET_VAL.
  - All counters are set to 0.
  - sw_rise, sw_fall and sw_chg are set to 0.
  - Outputs hold these values for as long as rst=1.
  - Release is sampled on the next clk edge.
- Synchroniser: per-bit two-flop chain, sw_i -> s1 -> s2. Only s2 is used downstream.
- Per-bit debounce, each bit fully independent:
  - Each bit has its own counter, width ceil(log2(DEBOUNCE_CYCLES+1)).
  - If s2[i] == sw_o[i]: counter[i] <= 0.
  - Else, if counter[i] == DEBOUNCE_CYCLES-1: sw_o[i] <= s2[i], counter[i] <= 0, and the matching rise/fall bit pulses high in the next cycle.
  - Else: counter[i] <= counter[i]+1.
- Acceptance rule:
  - A new level is accepted only after s2 differs from sw_o for DEBOUNCE_CYCLES consecutive cycles.
  - Any return to the old level before that point clears the count, so no output change occurs (bounce rejection).
- Latency: a clean input step is reflected on sw_o 2 + DEBOUNCE_CYCLES rising edges after it is first sampled by s1. There is ±1 cycle uncertainty from asynchronous sampling.
- DEBOUNCE_CYCLES=1: sw_o follows s2 with one register of delay, giving 3 cycles total.
- Pulses:
  - sw_rise[i] = sw_o[i] & ~sw_o_prev[i], registered.
  - sw_fall[i] = ~sw_o[i] & sw_o_prev[i], registered.
  - Each pulse is exactly one clk wide and occurs the cycle after the sw_o update.
- Several bits may change in the same cycle. Their pulses assert together and sw_chg is a single 1-cycle pulse.
- Counters saturate by construction: they never exceed DEBOUNCE_CYCLES-1 and there is no wrap-around.
- Reset asserted mid-count: the count is discarded and sw_o returns to RESET_VAL immediately. No pulse is generated by reset.
- sw_i held at X/Z: no requirement beyond reset values. The bench must drive sw_i before releasing rst.
- No combinational path from sw_i to any output.

Test Plan:
- Reset: DEBOUNCE_CYCLES=4; rst=1 with sw_i=4'b1111 for 100 ns -> sw_o=0000 and all pulses 0 throughout reset.
- One-hot walk: DEBOUNCE_CYCLES=4; rst released; sw_i=0001, 0010, 0100, 1000, each held 20 cycles:
  - sw_o follows each value 6±1 cycles after the change.
  - sw_rise shows one 1-cycle pulse on the new bit and sw_fall one pulse on the old bit, in the same cycle.
  - sw_chg pulses once per step.
- Bounce rejection: DEBOUNCE_CYCLES=4; sw_i[0] toggles 0/1 every 2 cycles for 20 cycles, then holds 1:
  - sw_o[0] stays 0 during toggling.
  - sw_o[0] goes 1 exactly 6±1 cycles after the final edge, with a single sw_rise[0] pulse.
- Glitch: DEBOUNCE_CYCLES=4; a 3-cycle high pulse on sw_i[2] -> no change on sw_o and no pulses.
- Simultaneous change: sw_i 0000 -> 1111 held -> all sw_o bits update in the same cycle, sw_rise=1111 for one cycle, sw_chg one pulse.
- Reset mid-count: sw_o=0001 and sw_i=0000; assert rst 2 cycles after the change -> sw_o=0000 immediately, with no sw_fall pulse.
